// File: rtl/wsp_scan_sequencer.sv
// IEEE 1500 WSP scan sequencer: one start request runs a capture/shift/update scan on the WIR or a data register.
// Build option WSP_SCAN_SEQ_CAPTURE_EN: when defined, a CAPTURE cycle precedes SHIFT; when undefined, IDLE goes straight to SHIFT.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | waiting for start, all strobes low
//   CAPTURE | CaptureWR high, bit index and dr_out cleared
//   SHIFT   | ShiftWR high, WSI = word[k], dr_out[k] <= WSO
//   UPDATE  | UpdateWR high, done follows in the next cycle
module wsp_scan_sequencer #(
   parameter int IR_LEN = 12,
   parameter int DR_MAX = 32,
   parameter int LW     = $clog2(DR_MAX + 1)
) (
   input  logic              WRCK,
   input  logic              WRSTN,
   input  logic              start,
   input  logic              op,
   input  logic [IR_LEN-1:0] ir_code,
   input  logic [DR_MAX-1:0] dr_in,
   input  logic [LW-1:0]     dr_len,
   input  logic              WSO,
   output logic              SelectWIR,
   output logic              CaptureWR,
   output logic              ShiftWR,
   output logic              UpdateWR,
   output logic              WSI,
   output logic              busy,
   output logic              done,
   output logic [DR_MAX-1:0] dr_out
);

   localparam int WW = (IR_LEN > DR_MAX) ? IR_LEN : DR_MAX;
   localparam int CW = $clog2(WW + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAPTURE,
      S_SHIFT,
      S_UPDATE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_op;
   logic              w_op_next;
   logic              w_accept;
   logic [CW-1:0]     r_len;
   logic [CW-1:0]     r_idx;
   logic [CW-1:0]     w_n;
   logic [WW-1:0]     r_sh;
   logic [WW-1:0]     w_word;
   logic [WW-1:0]     w_src;
   logic [DR_MAX-1:0] r_dr;
   logic              r_sel;
   logic              r_shift;
   logic              r_upd;
   logic              r_wsi;
   logic              r_busy;
   logic              r_done;

   assign w_accept  = (r_state == S_IDLE) && start;
   assign w_op_next = w_accept ? op : r_op;
   assign w_word    = op ? WW'(dr_in) : WW'(ir_code);
   assign w_n       = op ? ((dr_len > LW'(DR_MAX)) ? CW'(DR_MAX) : CW'(dr_len))
                         : CW'(IR_LEN);
   // Without a capture cycle the first bit must come straight from the inputs.
   assign w_src     = (r_state == S_IDLE) ? w_word : r_sh;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
`ifdef WSP_SCAN_SEQ_CAPTURE_EN
               w_next = S_CAPTURE;
`else
               w_next = (w_n == '0) ? S_UPDATE : S_SHIFT;
`endif
            end
         end
         S_CAPTURE: w_next = (r_len == '0) ? S_UPDATE : S_SHIFT;
         S_SHIFT:   w_next = (r_idx == r_len - 1'b1) ? S_UPDATE : S_SHIFT;
         S_UPDATE:  w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge WRCK or negedge WRSTN) begin
      if (!WRSTN) begin
         r_state <= S_IDLE;
         r_op    <= 1'b0;
         r_len   <= '0;
         r_idx   <= '0;
         r_sh    <= '0;
         r_dr    <= '0;
         r_sel   <= 1'b0;
         r_shift <= 1'b0;
         r_upd   <= 1'b0;
         r_wsi   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_op    <= w_op_next;
         r_sel   <= (w_next != S_IDLE) && !w_op_next;
         r_shift <= (w_next == S_SHIFT);
         r_upd   <= (w_next == S_UPDATE);
         r_busy  <= (w_next != S_IDLE);
         r_done  <= (r_state == S_UPDATE);

         if (w_accept) begin
            r_len <= w_n;
            r_idx <= '0;
            r_sh  <= w_word;
`ifndef WSP_SCAN_SEQ_CAPTURE_EN
            r_dr  <= '0;
`endif
         end

         if (r_state == S_CAPTURE) begin
            r_idx <= '0;
            r_dr  <= '0;
         end

         if (r_state == S_SHIFT) begin
            for (int i = 0; i < DR_MAX; i++) begin
               if (r_idx == CW'(i)) r_dr[i] <= WSO;
            end
            r_idx <= r_idx + 1'b1;
         end

         if (w_next == S_SHIFT) begin
            r_wsi <= w_src[0];
            r_sh  <= w_src >> 1;
         end else begin
            r_wsi <= 1'b0;
         end
      end
   end

`ifdef WSP_SCAN_SEQ_CAPTURE_EN
   logic r_cap;

   always_ff @(posedge WRCK or negedge WRSTN) begin
      if (!WRSTN) r_cap <= 1'b0;
      else        r_cap <= (w_next == S_CAPTURE);
   end

   assign CaptureWR = r_cap;
`else
   assign CaptureWR = 1'b0;
`endif

   assign SelectWIR = r_sel;
   assign ShiftWR   = r_shift;
   assign UpdateWR  = r_upd;
   assign WSI       = r_wsi;
   assign busy      = r_busy;
   assign done      = r_done;
   assign dr_out    = r_dr;

endmodule

// File: tb/tb_wsp_scan_sequencer.sv
// Scoreboard bench for wsp_scan_sequencer: each issued scan queues its expected result, a monitor checks it at done.
module tb_wsp_scan_sequencer;

`ifdef WSP_SCAN_SEQ_CAPTURE_EN
   localparam int CAP = 1;
`else
   localparam int CAP = 0;
`endif

   logic        WRCK    = 1'b0;
   logic        WRSTN   = 1'b0;
   logic        start   = 1'b0;
   logic        op      = 1'b0;
   logic [11:0] ir_code = '0;
   logic [31:0] dr_in   = '0;
   logic [5:0]  dr_len  = '0;
   logic        WSO     = 1'b0;
   logic        SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI, busy, done;
   logic [31:0] dr_out;

   wsp_scan_sequencer #(.IR_LEN(12), .DR_MAX(32), .LW(6)) dut (
      .WRCK(WRCK), .WRSTN(WRSTN), .start(start), .op(op), .ir_code(ir_code),
      .dr_in(dr_in), .dr_len(dr_len), .WSO(WSO), .SelectWIR(SelectWIR),
      .CaptureWR(CaptureWR), .ShiftWR(ShiftWR), .UpdateWR(UpdateWR), .WSI(WSI),
      .busy(busy), .done(done), .dr_out(dr_out)
   );

   always #5 WRCK = ~WRCK;

   int cyc = 0;
   always @(posedge WRCK) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mask(input int n);
      logic [31:0] m = '0;
      for (int i = 0; i < 32; i++) if (i < n) m[i] = 1'b1;
      return m;
   endfunction

   typedef struct {
      logic        op;
      logic [31:0] word;
      int          n;
      logic [31:0] exp_dr;
      int          c0;
   } exp_t;

   exp_t q[$];

   // Wrapped-core model: presents pat[k] on WSO during shift cycle k.
   logic [31:0] pat   = '0;
   int          wso_k = 0;
   always @(posedge WRCK) begin
      #2;
      if (ShiftWR) begin
         WSO = (wso_k < 32) ? pat[wso_k] : 1'b0;
         wso_k++;
      end else begin
         WSO   = 1'b0;
         wso_k = 0;
      end
   end

   int          cap_cnt, cap_cyc, sh_cnt, sh_first, upd_cnt, upd_cyc, busy_cnt;
   int          sel_chg, excl_bad, wsi_bad;
   int          idle_sel_bad = 0;
   logic [31:0] wsi_acc;
   logic        sel_val;
   exp_t        e;

   task automatic clr_acc();
      cap_cnt = 0; cap_cyc = -1; sh_cnt = 0; sh_first = -1; upd_cnt = 0; upd_cyc = -1;
      busy_cnt = 0; sel_chg = 0; excl_bad = 0; wsi_bad = 0; wsi_acc = '0; sel_val = 1'b0;
   endtask

   initial clr_acc();

   always @(negedge WRCK) begin
      if (!WRSTN) begin
         clr_acc();
      end else begin
         if (int'(CaptureWR) + int'(ShiftWR) + int'(UpdateWR) > 1) excl_bad++;
         if (WSI && !ShiftWR) wsi_bad++;
         if (busy) begin
            if (busy_cnt == 0) sel_val = SelectWIR;
            else if (SelectWIR !== sel_val) sel_chg++;
            busy_cnt++;
         end else if (SelectWIR) begin
            idle_sel_bad++;
         end
         if (CaptureWR) begin cap_cnt++; cap_cyc = cyc; end
         if (ShiftWR) begin
            if (sh_cnt == 0) sh_first = cyc;
            if (sh_cnt < 32) wsi_acc[sh_cnt] = WSI;
            sh_cnt++;
         end
         if (UpdateWR) begin upd_cnt++; upd_cyc = cyc; end
         if (done) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = q.pop_front();
               chk("cap_count",     cap_cnt,  CAP);
               chk("cap_cycle",     cap_cyc,  (CAP != 0) ? e.c0 + 1 : -1);
               chk("shift_count",   sh_cnt,   e.n);
               chk("shift_first",   sh_first, (e.n == 0) ? -1 : e.c0 + 1 + CAP);
               chk("wsi_bits",      wsi_acc,  e.word & mask(e.n));
               chk("upd_count",     upd_cnt,  1);
               chk("upd_cycle",     upd_cyc,  e.c0 + e.n + 1 + CAP);
               chk("done_cycle",    cyc,      e.c0 + e.n + 2 + CAP);
               chk("busy_cycles",   busy_cnt, e.n + 1 + CAP);
               chk("select",        sel_val,  !e.op);
               chk("select_stable", sel_chg,  0);
               chk("dr_out",        dr_out,   e.exp_dr);
               chk("strobe_excl",   excl_bad, 0);
               chk("wsi_idle",      wsi_bad,  0);
            end
            clr_acc();
         end
      end
   end

   task automatic issue(input logic o, input logic [11:0] ir, input logic [31:0] din,
                        input logic [5:0] len, input logic [31:0] p, input logic [31:0] exp_dr,
                        input bit b2b);
      exp_t x;
      int   n;
      n = o ? ((int'(len) > 32) ? 32 : int'(len)) : 12;
      @(posedge WRCK); #2;
      op = o; ir_code = ir; dr_in = din; dr_len = len; pat = p; start = 1'b1;
      x.op = o; x.word = o ? din : {20'h0, ir}; x.n = n; x.exp_dr = exp_dr; x.c0 = cyc;
      q.push_back(x);
      if (b2b) begin
         x.c0 = cyc + n + 2 + CAP;
         q.push_back(x);
      end
      repeat (b2b ? n + 3 + CAP : 1) @(posedge WRCK);
      #2;
      start = 1'b0; op = ~o; ir_code = ~ir; dr_in = ~din; dr_len = ~len;
   endtask

   task automatic wait_idle(input int bound);
      int k = 0;
      while (q.size() != 0 && k < bound) begin
         @(negedge WRCK); #1;
         k++;
      end
      if (q.size() != 0) begin
         chk("timeout_pending", q.size(), 0);
         q.delete();
      end
   endtask

   initial begin
      int seen;
      int u;

      start = 1'b1;
      repeat (3) begin
         @(negedge WRCK);
         chk("reset_strobes", {25'h0, SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI, busy, done}, 0);
         chk("reset_dr_out", dr_out, 0);
      end
      start = 1'b0;
      @(posedge WRCK); #2;
      WRSTN = 1'b1;
      repeat (2) @(posedge WRCK);

      // WS_EXTEST instruction load, core returns 0x5A3
      issue(1'b0, 12'b010010010010, 32'hFFFFFFFF, 6'd0, 32'hFFFFF5A3, 32'h0000_05A3, 1'b0);
      wait_idle(40);

      issue(1'b1, 12'hFFF, 32'h0000_00A5, 6'd8, 32'hFFFF_FF3C, 32'h0000_003C, 1'b0);
      wait_idle(40);
      repeat (3) @(negedge WRCK);
      chk("dr_out_hold", dr_out, 32'h0000_003C);

      issue(1'b1, 12'h000, 32'hFFFFFFFF, 6'd0, 32'hFFFFFFFF, 32'h0, 1'b0);
      wait_idle(20);

      issue(1'b1, 12'h000, 32'hDEADBEEF, 6'd40, 32'h12345678, 32'h12345678, 1'b0);
      wait_idle(60);

      issue(1'b1, 12'h000, 32'hFFFF_FF1A, 6'd5, 32'hFFFF_FFF5, 32'h0000_0015, 1'b0);
      wait_idle(30);

      issue(1'b1, 12'h000, 32'h0000_0006, 6'd3, 32'h0000_0005, 32'h0000_0005, 1'b1);
      wait_idle(60);

      // abort an IR scan at shift cycle 5
      @(posedge WRCK); #2;
      op = 1'b0; ir_code = 12'b010010010010; pat = 32'h0000_0FFF; start = 1'b1;
      @(posedge WRCK); #2;
      start = 1'b0;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge WRCK);
         if (ShiftWR) begin
            if (seen == 5) break;
            seen++;
         end
      end
      chk("abort_reached", seen, 5);
      #1 WRSTN = 1'b0;
      #1;
      chk("abort_shift", ShiftWR, 0);
      chk("abort_busy",  busy,    0);
      chk("abort_select", SelectWIR, 0);
      chk("abort_dr_out", dr_out, 0);
      repeat (2) @(posedge WRCK);
      #2 WRSTN = 1'b1;
      u = 0;
      repeat (20) begin
         @(negedge WRCK);
         if (UpdateWR || done || busy) u++;
      end
      chk("abort_quiet", u, 0);

      issue(1'b0, 12'hABC, 32'h0, 6'd0, 32'h0000_0ABC, 32'h0000_0ABC, 1'b0);
      wait_idle(40);

      repeat (3) @(negedge WRCK);
      chk("queue_empty", q.size(), 0);
      chk("idle_select", idle_sel_bad, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wsp_scan_sequencer.md
# wsp_scan_sequencer

Parallel-to-serial scan sequencer that drives the IEEE 1500 Wrapper Serial Port of a wrapped core. It sits directly upstream of the wrapped core. From a single `start` request it generates the `SelectWIR`/`CaptureWR`/`ShiftWR`/`UpdateWR` sequence, serialises an instruction or data word onto `WSI`, and collects `WSO` into a parallel result. It replaces hand-timed control stimulus and the free-running serial shifter for instruction loads (e.g. WS_EXTEST code 12'b010010010010) and WBY/WBR data scans.

## Interface
- `IR_LEN`, 12, WIR instruction length in bits
- `DR_MAX`, 32, maximum data-register scan length in bits
- `LW`, $clog2(DR_MAX+1), width of `dr_len`
- `WRCK` input 1: wrapper clock; all state changes on its rising edge.
- `WRSTN` input 1: reset, asynchronous, active-low.
- `start` input 1: request a scan; sampled only in IDLE.
- `op` input 1: scan type, 0 = instruction scan (WIR), 1 = data scan (WBY/WBR); sampled with `start`.
- `ir_code` input IR_LEN: instruction to load; sampled with `start`.
- `dr_in` input DR_MAX: data to shift in; sampled with `start`.
- `dr_len` input LW: data-scan length; sampled with `start`.
- `WSO` input 1: serial output returned from the wrapped core.
- `SelectWIR` output 1: wrapper select, 1 during instruction scans.
- `CaptureWR` output 1: capture strobe.
- `ShiftWR` output 1: shift enable.
- `UpdateWR` output 1: update strobe.
- `WSI` output 1: serial data to the wrapped core.
- `busy` output 1: scan in progress.
- `done` output 1: one-cycle completion pulse.
- `dr_out` output DR_MAX: bits collected from `WSO`.

## Operation
- FSM states: IDLE → CAPTURE → SHIFT → UPDATE → IDLE.
- Reset puts the FSM in IDLE. Every output resets to 0, including `dr_out`.
- IDLE behaviour:
  - `start`=1 latches `op`, the shift word and N, then moves to CAPTURE.
  - For `op`=0: N = IR_LEN and the word is `ir_code`.
  - For `op`=1: N = min(`dr_len`, DR_MAX) and the word is `dr_in`.
- CAPTURE (1 cycle):
  - `CaptureWR`=1.
  - Bit counter is cleared and `dr_out` is cleared.
- SHIFT (N cycles):
  - `ShiftWR`=1.
  - On cycle k (k = 0..N-1), `WSI` = word[k], LSB first.
  - On the rising edge that ends cycle k, `dr_out[k]` <= `WSO`.
  - Bits N..DR_MAX-1 of `dr_out` remain 0.
- UPDATE (1 cycle): `UpdateWR`=1. Then return to IDLE with `done`=1 for one cycle.
- `SelectWIR` = latched `op`==0. It is held constant from CAPTURE through UPDATE and is 0 in IDLE.
- At most one of `CaptureWR`/`ShiftWR`/`UpdateWR` is high in any cycle.
- `WSI`=0 outside SHIFT.
- `busy`=1 in CAPTURE, SHIFT and UPDATE.
- Boundary conditions:
  - N=0 (data scan with `dr_len`=0): SHIFT is skipped and UPDATE follows CAPTURE directly. `dr_out` stays 0.
  - `dr_len` > DR_MAX is clamped to DR_MAX.
  - `start` while `busy`=1 is ignored. No queueing.
  - `start` in the `done` cycle is accepted, giving back-to-back scans.
  - `WRSTN` low mid-scan: all strobes drop immediately (asynchronous). The scan is abandoned, no `done` is issued, and `dr_out` is cleared.
- `dr_out` holds its value from the end of SHIFT until the next CAPTURE.

## Timing
- All outputs are registered.
- Cycle 0 is the cycle in which `start` is sampled high.
- `CaptureWR`: cycle 1.
- `ShiftWR`: cycles 2..N+1.
- `UpdateWR`: cycle N+2.
- `done`: cycle N+3.
- `busy`: cycles 1..N+2.
- `dr_out` is final from cycle N+2.
- Total latency from start to done = N+3 cycles.
- `WSO` is sampled on rising edges only. The core updates `WSO` so that it is stable before each of those edges.

## Configuration
- Macro: `WSP_SCAN_SEQ_CAPTURE_EN`.
- Defined:
  - CAPTURE state is present, as described above.
- Undefined:
  - CAPTURE is removed. IDLE goes directly to SHIFT, and `dr_out` is cleared on start acceptance instead.
  - `CaptureWR` is tied to 0.
  - Every listed cycle index above is reduced by 1. Latency is N+2.

## Test plan
- Reset: hold `WRSTN`=0, pulse `start` → all outputs 0, `busy` stays 0.
- IR scan: `op`=0, `ir_code`=12'b010010010010 → `SelectWIR`=1 on cycles 1–14; `WSI` on cycles 2–13 = 0,1,0,0,1,0,0,1,0,0,1,0; `UpdateWR` on cycle 14; `done` on cycle 15.
- DR scan: `op`=1, `dr_len`=8, `dr_in`=8'hA5, bench drives `WSO` with bits of 8'h3C LSB first → `WSI` = 1,0,1,0,0,1,0,1; `dr_out`=32'h0000003C; `SelectWIR`=0 throughout.
- Length edges: `dr_len`=0 → `CaptureWR` in cycle 1, `UpdateWR` in cycle 2, `done` in cycle 3. `dr_len`=40 with DR_MAX=32 → exactly 32 `ShiftWR` cycles.
- Collisions: `start` held high during a scan → ignored until `done`. `start` in the `done` cycle → new `CaptureWR` on the next cycle.
- Abort: `WRSTN` low at shift cycle 5 of a 12-bit IR scan → `ShiftWR`/`busy` drop immediately, no `UpdateWR` and no `done`. A fresh scan after reset completes normally. Rerun the IR scan with `WSP_SCAN_SEQ_CAPTURE_EN` undefined → `done` on cycle 14.
